multiplier_seq: RTL and testbench

//   Multi-channel fractional (Q1.(BITSIZE-1)) audio multiplier for gain, VCA and ring-mod paths.

---
 rtl/multiplier_seq.sv | 139 +++++++++++++
 tb/tb_multiplier_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/multiplier_seq.sv
// Serial shift-add Q1.(BITSIZE-1) multiplier, CHANNELS products per lrclk frame.
// Define MULTIPLIER_ROUND_EN for round-half-up instead of truncation.
module multiplier_seq #(
    parameter int BITSIZE  = 16,
    parameter int CHANNELS = 2
) (
    input  logic                         bclk,
    input  logic                         reset,
    input  logic                         lrclk,
    input  logic [CHANNELS*BITSIZE-1:0]  in1,
    input  logic [CHANNELS*BITSIZE-1:0]  in2,
    output logic [CHANNELS*BITSIZE-1:0]  out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int W    = BITSIZE;
    localparam int PW   = 2 * W;
    localparam int CNTW = $clog2(W);
    localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic signed [PW-1:0] RMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] RMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    generate
        if (!(BITSIZE == 16 || BITSIZE == 24)) begin : g_bad_width
            $error("multiplier_seq: BITSIZE must be 16 or 24");
        end
        if (CHANNELS * (BITSIZE + 2) + 1 >= 64) begin : g_bad_budget
            $error("multiplier_seq: frame does not fit in 64 bclk cycles");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, LOAD, MUL, STORE, DONE} state_t;

    state_t state, state_n;

    logic                        lrclk_q;
    logic                        frame_edge;
    logic [CHANNELS*W-1:0]       op1, op2, res;
    logic [CHW-1:0]              ch;
    logic [CNTW-1:0]             cnt;
    logic                        sign;
    logic [PW-1:0]               ma, acc;
    logic [W-1:0]                mb;
    logic [W-1:0]                a_cur, b_cur;
    logic [PW-1:0]               prod;
    logic signed [PW-1:0]        rsh;
    logic [W-1:0]                sat;

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? (~v + 1'b1) : v;
    endfunction

    assign frame_edge = lrclk & ~lrclk_q;
    assign a_cur = op1[int'(ch)*W +: W];
    assign b_cur = op2[int'(ch)*W +: W];

    always_ff @(posedge bclk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (frame_edge) state_n = LOAD;
            LOAD:  state_n = MUL;
            MUL:   if (cnt == CNTW'(W-1)) state_n = STORE;
            STORE: state_n = (ch == CHW'(CHANNELS-1)) ? DONE : LOAD;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Sign-magnitude product back to two's complement, then Q-format rescale.
    always_comb begin
        prod = sign ? (~acc + 1'b1) : acc;
`ifdef MULTIPLIER_ROUND_EN
        prod = prod + (PW'(1) << (W-2));
`endif
        rsh = $signed(prod) >>> (W-1);
        if (rsh > RMAX)      sat = RMAX[W-1:0];
        else if (rsh < RMIN) sat = RMIN[W-1:0];
        else                 sat = rsh[W-1:0];
    end

    always_ff @(posedge bclk) begin
        if (reset) begin
            lrclk_q   <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            ch        <= '0;
            cnt       <= '0;
        end else begin
            lrclk_q   <= lrclk;
            out_valid <= 1'b0;
            if (frame_edge && state != IDLE) overrun <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (frame_edge) begin
                        op1  <= in1;
                        op2  <= in2;
                        ch   <= '0;
                        busy <= 1'b1;
                    end
                end
                LOAD: begin
                    sign <= a_cur[W-1] ^ b_cur[W-1];
                    ma   <= {{W{1'b0}}, mag(a_cur)};
                    mb   <= mag(b_cur);
                    acc  <= '0;
                    cnt  <= '0;
                end
                // Shifting ma/mb is equivalent to adding mag_a << cnt for bit cnt.
                MUL: begin
                    if (mb[0]) acc <= acc + ma;
                    ma  <= ma << 1;
                    mb  <= mb >> 1;
                    cnt <= cnt + 1'b1;
                end
                STORE: begin
                    res[int'(ch)*W +: W] <= sat;
                    ch <= ch + 1'b1;
                end
                DONE: begin
                    out       <= res;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_seq.sv
// Bench for multiplier_seq: 16/2 instance plus a 24/2 instance,
// checked against an integer-arithmetic reference model.
module tb_multiplier_seq;

    logic        bclk = 1'b0;
    logic        reset = 1'b1;
    logic        lr16 = 1'b0;
    logic        lr24 = 1'b0;
    logic [31:0] in1_16 = '0, in2_16 = '0, out16;
    logic [47:0] in1_24 = '0, in2_24 = '0, out24;
    logic        ov16, bz16, or16;
    logic        ov24, bz24, or24;

    int passes = 0;
    int total  = 0;

    always #5 bclk = ~bclk;

    multiplier_seq #(.BITSIZE(16), .CHANNELS(2)) u16 (
        .bclk(bclk), .reset(reset), .lrclk(lr16),
        .in1(in1_16), .in2(in2_16), .out(out16),
        .out_valid(ov16), .busy(bz16), .overrun(or16)
    );

    multiplier_seq #(.BITSIZE(24), .CHANNELS(2)) u24 (
        .bclk(bclk), .reset(reset), .lrclk(lr24),
        .in1(in1_24), .in2(in2_24), .out(out24),
        .out_valid(ov24), .busy(bz24), .overrun(or24)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Q1.(w-1) product with plain integer arithmetic.
    function automatic logic [23:0] model(input int w, input logic [23:0] a,
                                          input logic [23:0] b);
        longint sa, sb, p, r, mx;
        sa = longint'(a);
        sb = longint'(b);
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
`ifdef MULTIPLIER_ROUND_EN
        p = p + (longint'(1) << (w-2));
`endif
        r  = p >>> (w-1);
        mx = (longint'(1) << (w-1)) - 1;
        if (r > mx)      r = mx;
        if (r < -mx - 1) r = -mx - 1;
        return 24'(r & ((longint'(1) << w) - 1));
    endfunction

    task automatic run_frame(input string tag, input bit big,
                             input logic [47:0] a, input logic [47:0] b,
                             input bit disturb);
        int w, lat, n;
        logic [47:0] msk, o;
        w   = big ? 24 : 16;
        lat = big ? 53 : 37;
        msk = (48'h1 << w) - 1;
        @(negedge bclk);
        if (big) begin in1_24 = a; in2_24 = b; lr24 = 1'b1; end
        else begin in1_16 = a[31:0]; in2_16 = b[31:0]; lr16 = 1'b1; end
        @(posedge bclk); #1;
        chk({tag, "_busy"}, big ? bz24 : bz16, 1'b1);
        @(negedge bclk);
        lr16 = 1'b0;
        lr24 = 1'b0;
        if (disturb) begin
            in1_16 = $urandom;
            in2_16 = $urandom;
        end
        n = 0;
        while (n < 80) begin
            if (disturb && n == 19) begin @(negedge bclk); lr16 = 1'b1; end
            if (disturb && n == 20) begin @(negedge bclk); lr16 = 1'b0; end
            @(posedge bclk); #1;
            n++;
            if (disturb && n == 20) chk({tag, "_ovr_set"}, or16, 1'b1);
            if (big ? ov24 : ov16) break;
        end
        chk({tag, "_lat"}, n, lat);
        o = big ? out24 : {16'h0, out16};
        for (int k = 0; k < 2; k++)
            chk($sformatf("%s_ch%0d", tag, k), (o >> (k*w)) & msk,
                model(w, 24'((a >> (k*w)) & msk), 24'((b >> (k*w)) & msk)));
        chk({tag, "_idle"}, big ? bz24 : bz16, 1'b0);
        @(posedge bclk); #1;
        chk({tag, "_pulse"}, big ? ov24 : ov16, 1'b0);
    endtask

    initial begin
        logic saw;
        repeat (3) @(posedge bclk);
        #1;
        chk("rst_out", out16, 0);
        chk("rst_valid", ov16, 0);
        chk("rst_busy", bz16, 0);
        chk("rst_ovr", or16, 0);
        @(negedge bclk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (10) begin @(posedge bclk); #1; saw = saw | ov16 | bz16; end
        chk("quiet", saw, 1'b0);

        run_frame("half", 0, 48'h8000_4000, 48'h4000_4000, 0);
        chk("half_ch0", out16[15:0], 16'h2000);
        chk("half_ch1", out16[31:16], 16'hC000);
        run_frame("sat", 0, 48'h7FFF_8000, 48'h8000_8000, 0);
        chk("sat_ch0", out16[15:0], 16'h7FFF);
        chk("sat_ch1", out16[31:16], 16'h8001);
        run_frame("lsb", 0, 48'hFFFF_0001, 48'h4000_4000, 0);
`ifdef MULTIPLIER_ROUND_EN
        chk("lsb_k0", out16, 32'h0000_0001);
`else
        chk("lsb_k0", out16, 32'hFFFF_0000);
`endif
        for (int i = 0; i < 6; i++)
            run_frame($sformatf("rnd%0d", i), 0, 48'($urandom), 48'($urandom), 0);

        @(negedge bclk);
        in1_16 = 32'h1234_5678; in2_16 = 32'h7654_4321; lr16 = 1'b1;
        @(posedge bclk);
        @(negedge bclk);
        lr16 = 1'b0;
        repeat (9) @(negedge bclk);
        reset = 1'b1;
        @(posedge bclk); #1;
        chk("mrst_out", out16, 0);
        chk("mrst_busy", bz16, 0);
        @(negedge bclk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (45) begin @(posedge bclk); #1; saw = saw | ov16; end
        chk("mrst_novalid", saw, 1'b0);
        run_frame("post", 0, 48'h1234_5678, 48'h7654_4321, 0);

        chk("ovr_clear", or16, 0);
        run_frame("ovr", 0, 48'hC000_6000, 48'h5000_A000, 1);
        chk("ovr_held", or16, 1'b1);
        run_frame("after", 0, 48'($urandom), 48'($urandom), 0);
        chk("ovr_sticky", or16, 1'b1);

        run_frame("w24", 1, 48'h400000_400000, 48'hC00000_C00000, 0);
        chk("w24_ch0", out24[23:0], 24'hE00000);
        for (int i = 0; i < 3; i++)
            run_frame($sformatf("w24r%0d", i), 1,
                      {24'($urandom), 24'($urandom)},
                      {24'($urandom), 24'($urandom)}, 0);
        chk("w24_ovr", or24, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
